// File: rtl/division_sub.sv
// ----------------------------------------------------------------------------
// division_sub
//   Repeated-subtraction unsigned divider. The dividend and then the divisor
//   arrive on a shared input bus on consecutive cycles. The control FSM
//   subtracts the divisor from the remainder register once per cycle, counting
//   the subtractions in the quotient register, until the remainder drops below
//   the divisor. The result is reported through a start/done handshake.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset, aborts any operation
//   start        division request, only honoured in IDLE
//   data_in      dividend in the start cycle, divisor in the following cycle
//   busy         high from LOAD_B through DONE
//   done         one-cycle pulse, results valid
//   quotient     unsigned quotient (all-ones on divide by zero)
//   remainder    unsigned remainder (dividend on divide by zero)
//   div_by_zero  set with done when the divisor was zero, held until next start
// ----------------------------------------------------------------------------
module division_sub #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic divisor_is_zero;
    logic can_subtract;

    assign divisor_is_zero = (divisor_q == '0);
    assign can_subtract    = (remainder_q >= divisor_q);

    // State and datapath registers; reset clears everything so all outputs
    // read zero and an in-flight operation is dropped without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            remainder_q   <= '0;
            quotient_q    <= '0;
            divisor_q     <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            remainder_q   <= remainder_d;
            quotient_q    <= quotient_d;
            divisor_q     <= divisor_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    // Next-state logic. RUN makes one keep-going/stop decision per cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD_B;
            LOAD_B:  state_d = RUN;
            RUN: begin
                if (divisor_is_zero || !can_subtract) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates. Registers hold by default so results stay visible
    // in IDLE until the next accepted start.
    always_comb begin
        remainder_d   = remainder_q;
        quotient_d    = quotient_q;
        divisor_d     = divisor_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remainder_d   = data_in;
                    quotient_d    = '0;
                    div_by_zero_d = 1'b0;
                end
            end
            LOAD_B: begin
                divisor_d = data_in;
            end
            RUN: begin
                // The zero check must come first: with a zero divisor the
                // >= guard is always true and the loop would never end.
                if (divisor_is_zero) begin
                    div_by_zero_d = 1'b1;
                    quotient_d    = ALL_ONES;
                end else if (can_subtract) begin
                    remainder_d = remainder_q - divisor_q;
                    quotient_d  = quotient_q + ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs are decoded from state or taken straight from registers, so
    // nothing on the input side reaches an output combinationally.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = div_by_zero_q;
    end

endmodule

// File: doc/division_sub.md
Name: division_sub

Overview:
- Repeated-subtraction unsigned divider; the inverse of the team's repeated-addition multiplier datapath.
- A shared input bus loads the dividend and then the divisor on consecutive cycles.
- An internal control FSM subtracts the divisor from a remainder register and increments a quotient register until the remainder drops below the divisor.
- Results and status return to the surrounding controller through a start/done handshake.

Parameters:
- WIDTH, 15, width of the data bus, dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a division; sampled only in IDLE.
- data_in  input  WIDTH  shared bus: dividend in the start cycle, divisor in the following cycle.
- busy  output  1  high from the cycle after accepted start until the DONE cycle inclusive.
- done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  high with done when the divisor was 0; holds until the next accepted start.

Behaviour:
- Reset: rst=1 at a clock edge forces state to IDLE and clears every register. All outputs become 0 (busy, done, quotient, remainder, div_by_zero). A reset mid-operation aborts the operation and produces no done pulse.
- States: IDLE, LOAD_B, RUN, DONE. All outputs are registered or decoded from state. There are no combinational paths from inputs to outputs.
- IDLE:
  - If start=1, capture data_in into remainder, clear quotient, clear div_by_zero, go to LOAD_B.
  - Otherwise hold all registers. Previous results stay visible.
- LOAD_B: capture data_in into the divisor register, go to RUN. start is ignored.
- RUN (one decision per cycle):
  - Divisor==0: set div_by_zero=1, force quotient to all-ones, leave remainder equal to the dividend, go to DONE.
  - Else if remainder >= divisor: remainder <= remainder - divisor, quotient <= quotient + 1, stay in RUN.
  - Else go to DONE.
- DONE: done=1 for exactly this cycle, busy=1, then go to IDLE unconditionally. start is ignored in DONE; it is accepted from the following cycle.
- Latency: count the start cycle as cycle 0. done is high in cycle q+3, where q is the final quotient. With a zero divisor, done is high in cycle 3.
- Width and arithmetic:
  - All values are unsigned WIDTH bits and the comparison is unsigned.
  - The subtraction never underflows because of the >= guard.
  - The quotient cannot overflow because it is at most the dividend.
- Intermediate values: quotient and remainder change every RUN cycle. They are defined as valid only while done=1 and afterwards in IDLE.
- start while busy: ignored. It does not queue, restart or corrupt the operation.
- Dividend < divisor: q=0, remainder=dividend, done in cycle 3.
- Dividend 0 with nonzero divisor: quotient=0, remainder=0, done in cycle 3.
- Worst case: 32767/1 takes 32767 RUN subtractions. There is no timeout.

Test Plan:
- start with data_in=100, then 7 -> done high only in cycle 17; quotient=14, remainder=2, div_by_zero=0; busy high cycles 1..17; results held while idle afterwards.
- 5/9 -> done in cycle 3; quotient=0, remainder=5. Also 21/7 -> done in cycle 6; quotient=3, remainder=0.
- 42/0 -> done in cycle 3; div_by_zero=1, quotient=0x7FFF, remainder=42. A following 9/3 -> div_by_zero clears in the accept cycle; quotient=3, remainder=0.
- 32767/1 -> done in cycle 32770; quotient=32767, remainder=0. Confirms no overflow and exactly one done pulse.
- Pulse start=1 with different data_in during LOAD_B, RUN and DONE of 100/7 -> result is still 14 r 2. No second operation starts unless start=1 in IDLE after DONE.
- Assert rst in RUN cycle 8 of 100/7 -> the next cycle shows IDLE with all outputs 0 and no done pulse. A new 50/6 afterwards -> quotient=8, remainder=2, done in cycle 11.
